// File: rtl/seq_sub32.sv
// Sequential slice-by-slice subtractor: diff = a - b - bin, one SLICE_W slice per RUN cycle.
// Optional early finish when the remaining slices of a and b match: define SEQ_SUB32_BORROW_SKIP_EN.
module seq_sub32 #(
  parameter int W       = 32,
  parameter int SLICE_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         overflow
);

  localparam int NSLICE = W / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W:0]   slice_sub;
  logic [W-1:0]       hi_mask;
  logic [W-1:0]       diff_run;
  logic               skip_hit;

  // Zero-extended subtraction: the extra MSB is set exactly when the slice goes negative.
  always_comb begin
    a_slice   = a_q[k_q*SLICE_W +: SLICE_W];
    b_slice   = b_q[k_q*SLICE_W +: SLICE_W];
    slice_sub = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE_W{1'b0}}, borrow_q};
    hi_mask   = {W{1'b1}} << (k_q * SLICE_W);
    diff_run  = diff_q;
    diff_run[k_q*SLICE_W +: SLICE_W] = slice_sub[SLICE_W-1:0];
`ifdef SEQ_SUB32_BORROW_SKIP_EN
    skip_hit  = (((a_q ^ b_q) & hi_mask) == '0);
`else
    skip_hit  = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          k_d      = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Equal remaining slices just pass the borrow through, giving all-ones or all-zeros.
        if (skip_hit) begin
          diff_d  = (diff_q & ~hi_mask) | (hi_mask & {W{borrow_q}});
          bout_d  = borrow_q;
          state_d = DONE;
        end else begin
          diff_d   = diff_run;
          borrow_d = slice_sub[SLICE_W];
          k_d      = k_q + 1'b1;
          if (k_q == K_LAST) begin
            bout_d  = slice_sub[SLICE_W];
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == RUN && state_d == DONE) begin
      ovf_d = (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ diff_d[W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule
